// File: rtl/lsu_pkg.sv
// Shared sizing helpers, funct3 size codes and FSM state type for the load/store unit.
package lsu_pkg;

  localparam int LSU_XLEN = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    size_bytes = 4'd1;
      2'd1:    size_bytes = 4'd2;
      2'd2:    size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

  // Natural alignment of the in-word offset for the access size.
  function automatic logic [2:0] align_off(input logic [2:0] f3, input logic [2:0] off);
    align_off = off & ~3'(size_bytes(f3) - 4'd1);
  endfunction

  function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [2:0] off);
    logic [15:0] m;
    m = 16'((16'd1 << size_bytes(f3)) - 16'd1);
    lane_mask = 8'(m << off);
  endfunction

  function automatic logic [LSU_XLEN-1:0] extend(input logic [LSU_XLEN-1:0] word,
                                                 input logic [2:0] f3, input logic [2:0] off);
    logic [LSU_XLEN-1:0] s;
    s = word >> {off, 3'b000};
    case (f3)
      F3_B:    extend = {{56{s[7]}}, s[7:0]};
      F3_H:    extend = {{48{s[15]}}, s[15:0]};
      F3_W:    extend = {{32{s[31]}}, s[31:0]};
      F3_BU:   extend = {56'd0, s[7:0]};
      F3_HU:   extend = {48'd0, s[15:0]};
      F3_WU:   extend = {32'd0, s[31:0]};
      default: extend = s;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_lane_merge.sv
// Combinational store merge: replaces the sized byte lanes of the old memory word with wdata.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [LSU_XLEN-1:0] old_word,
  input  logic [LSU_XLEN-1:0] wdata,
  input  logic [2:0]          funct3,
  input  logic [2:0]          off,
  output logic [LSU_XLEN-1:0] new_word
);

  logic [7:0]          mask;
  logic [LSU_XLEN-1:0] shifted;

  assign mask    = lane_mask(funct3, off);
  assign shifted = wdata << {off, 3'b000};

  for (genvar k = 0; k < 8; k++) begin : g_lane
    assign new_word[8*k +: 8] = mask[k] ? shifted[8*k +: 8] : old_word[8*k +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, RMW for sub-doubleword stores, sized/extended loads.
// Define MISALIGN_TRAP_EN to fault misaligned H/W/D accesses instead of force-aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN       = LSU_XLEN,
  parameter int DMEM_BYTES = 256
) (
  input  logic            Clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_Data_write,
  output logic            mem_MemWrite,
  output logic            mem_MemRead,
  input  logic [XLEN-1:0] mem_Data_read
);

  lsu_state_e      state, state_n;
  logic            store_q, fault_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q, wdata_q, word_q, merged;
  logic [2:0]      off_q;
  logic [3:0]      sz;
  logic [XLEN:0]   end_addr;
  logic            fault_in, misal;
  logic            accept;

  assign sz       = size_bytes(req_funct3);
  assign end_addr = {1'b0, req_addr} + (XLEN+1)'(sz);
`ifdef MISALIGN_TRAP_EN
  assign misal = |(req_addr[2:0] & 3'(sz - 4'd1));
`else
  assign misal = 1'b0;
`endif
  assign fault_in = (req_funct3 == 3'b111) || (req_store && req_funct3[2]) ||
                    (end_addr > (XLEN+1)'(DMEM_BYTES)) || misal;
  assign accept   = req_valid && (state == IDLE);

  // Non-faulting accesses are already aligned when trapping, so forcing alignment is always safe.
  assign off_q = align_off(f3_q, addr_q[2:0]);

  lsu_lane_merge u_merge (
    .old_word (word_q),
    .wdata    (wdata_q),
    .funct3   (f3_q),
    .off      (off_q),
    .new_word (merged)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      store_q <= 1'b0;
      fault_q <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        store_q <= req_store;
        fault_q <= fault_in;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == RD) word_q <= mem_Data_read;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (req_valid) begin
        if (fault_in)                      state_n = RESP;
        else if (req_store && sz == 4'd8)  state_n = WR;
        else                               state_n = RD;
      end
      RD:      state_n = store_q ? WR : RESP;
      WR:      state_n = RESP;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_fault     = 1'b0;
    resp_rdata     = '0;
    mem_MemRead    = 1'b0;
    mem_MemWrite   = 1'b0;
    mem_Data_write = '0;
    mem_address    = {addr_q[XLEN-1:3], 3'b000};
    case (state)
      IDLE: req_ready = 1'b1;
      RD:   mem_MemRead = 1'b1;
      WR: begin
        mem_MemWrite   = 1'b1;
        mem_Data_write = merged;
      end
      default: begin
        resp_valid = 1'b1;
        resp_fault = fault_q;
        if (!fault_q && !store_q) resp_rdata = extend(word_q, f3_q, off_q);
      end
    endcase
  end

endmodule
